// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and widths, also used by the SoC UART transmitter
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_BC_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - serial line, bit period and received-byte bundle for uart_receiver
interface uart_receiver_if;
  import uart_pkg::*;

  logic [UART_BC_W-1:0]      bc;
  logic                      rx;
  logic                      ch_vld;
  logic [UART_DATA_BITS-1:0] ch;

  modport master (
    output bc,
    output rx,
    input  ch_vld,
    input  ch
  );

  modport slave (
    input  bc,
    input  rx,
    output ch_vld,
    output ch
  );

endinterface

// File: rtl/uart_receiver_sync_2ff.sv
// rtl/uart_receiver_sync_2ff.sv - generic two-flop synchronizer with a programmable reset value
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= rst_val;
      q    <= rst_val;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with runtime bit period bc+1 clocks and mid-bit sampling
module uart_receiver
  import uart_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  uart_receiver_if.slave  rxif
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_rx_state_e            state, state_n;
  logic [UART_BC_W-1:0]      cnt, cnt_n;
  logic [2:0]                bit_idx, bit_idx_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic [UART_DATA_BITS-1:0] ch_n;
  logic                      ch_vld_n;
  logic                      rx_s;
  logic [UART_BC_W-1:0]      h;

  // Line idles high, so the synchronizer must come out of reset at 1 to avoid a phantom start.
  sync_2ff #(.WIDTH(1)) u_rx_sync (
    .clk     (clk),
    .rst     (rst),
    .rst_val (1'b1),
    .d       (rxif.rx),
    .q       (rx_s)
  );

  assign h = rxif.bc >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rxif.ch     <= '0;
      rxif.ch_vld <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      rxif.ch     <= ch_n;
      rxif.ch_vld <= ch_vld_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    ch_n      = rxif.ch;
    ch_vld_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end

      // Half a bit in, the line must still be low or the edge was a glitch.
      START: begin
        if (cnt != h) begin
          cnt_n = cnt + 1'b1;
        end else if (!rx_s) begin
          state_n   = DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
        end else begin
          state_n = IDLE;
        end
      end

      DATA: begin
        if (cnt != rxif.bc) begin
          cnt_n = cnt + 1'b1;
        end else begin
          shreg_n   = {rx_s, shreg[UART_DATA_BITS-1:1]};
          cnt_n     = '0;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) begin
            state_n = STOP;
          end
        end
      end

      // A low stop bit drops the byte silently; IDLE re-arms straight away to resynchronise.
      STOP: begin
        if (cnt != rxif.bc) begin
          cnt_n = cnt + 1'b1;
        end else begin
          if (rx_s) begin
            ch_n     = shreg;
            ch_vld_n = 1'b1;
          end
          cnt_n   = '0;
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver against a frame-timing reference model
module tb_uart_receiver;
  import uart_pkg::*;

  typedef struct {
    logic [7:0] d;
    int         e;
  } strobe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   bc_cur = 9;
  int   vld_double = 0;
  logic prev_vld = 1'b0;
  logic [7:0] last_ch = 8'h00;

  strobe_t obs_q[$];
  strobe_t exp_q[$];

  uart_receiver_if bus ();

  uart_receiver dut (
    .clk  (clk),
    .rst  (rst),
    .rxif (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.ch_vld) begin
      obs_q.push_back('{bus.ch, cyc});
      if (prev_vld) vld_double <= vld_double + 1;
    end
    prev_vld <= bus.ch_vld;
  end

  // Reference: a frame launched just after edge L strobes in the cycle after edge L+4+bc/2+9(bc+1).
  function automatic int exp_edge(input int launch, input int b);
    return launch + 4 + b / 2 + 9 * (b + 1);
  endfunction

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_bc(input int b);
    bus.bc = 16'(b);
    bc_cur = b;
    idle(2 * (b + 1));
  endtask

  task automatic expect_byte(input logic [7:0] d, input int launch);
    exp_q.push_back('{d, exp_edge(launch, bc_cur)});
    last_ch = d;
  endtask

  task automatic clear_queues();
    obs_q.delete();
    exp_q.delete();
  endtask

  // Drives one 8N1 frame starting now; abort_bit >= 0 pulses reset mid-way through that frame bit.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int abort_bit, output int launch);
    logic [9:0] bits;
    bits   = {stop, d, 1'b0};
    launch = cyc;
    for (int j = 0; j < 10; j++) begin
      bus.rx = bits[j];
      if (j == abort_bit) begin
        repeat (bc_cur / 2 + 1) @(posedge clk);
        #1;
        rst    = 1'b1;
        bus.rx = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      repeat (bc_cur + 1) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    bus.rx = 1'b1;
    bus.bc = 16'd9;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ch_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_ch_vld: got %b expected 0", bus.ch_vld);
    end
    checks++;
    if (bus.ch !== 8'h00) begin
      failures++;
      $display("FAIL reset_ch: got %h expected 00", bus.ch);
    end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_single(input int b, input logic [7:0] d, input string tag);
    int l;
    set_bc(b);
    clear_queues();
    send_frame(d, 1'b1, -1, l);
    expect_byte(d, l);
    idle(2 * (b + 1) + 10);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d strobes expected %0d", tag, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i].d !== exp_q[i].d) begin
          failures++;
          $display("FAIL %s_data: got %h expected %h", tag, obs_q[i].d, exp_q[i].d);
        end
        checks++;
        if (obs_q[i].e !== exp_q[i].e) begin
          failures++;
          $display("FAIL %s_edge: got %0d expected %0d", tag, obs_q[i].e, exp_q[i].e);
        end
      end
    end
    checks++;
    if (bus.ch !== d) begin
      failures++;
      $display("FAIL %s_ch_held: got %h expected %h", tag, bus.ch, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [4];
    int l;
    msg = '{8'h48, 8'h69, 8'h0A, 8'h10};
    set_bc(9);
    clear_queues();
    foreach (msg[k]) begin
      send_frame(msg[k], 1'b1, -1, l);
      expect_byte(msg[k], l);
    end
    idle(30);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i].d !== exp_q[i].d || obs_q[i].e !== exp_q[i].e) begin
          failures++;
          $display("FAIL b2b_byte%0d: got %h@%0d expected %h@%0d", i, obs_q[i].d, obs_q[i].e, exp_q[i].d, exp_q[i].e);
        end
      end
    end
  endtask

  task automatic test_false_start();
    int l;
    set_bc(9);
    clear_queues();
    bus.rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(30);
    checks++;
    if (obs_q.size() !== 0) begin
      failures++;
      $display("FAIL glitch_strobe: got %0d strobes expected 0", obs_q.size());
    end
    checks++;
    if (dut.state !== IDLE) begin
      failures++;
      $display("FAIL glitch_state: got %0d expected %0d", dut.state, IDLE);
    end
    send_frame(8'h55, 1'b1, -1, l);
    expect_byte(8'h55, l);
    idle(30);
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL glitch_next_count: got %0d strobes expected 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].d !== 8'h55 || obs_q[0].e !== exp_q[0].e) begin
        failures++;
        $display("FAIL glitch_next_byte: got %h@%0d expected 55@%0d", obs_q[0].d, obs_q[0].e, exp_q[0].e);
      end
    end
  endtask

  task automatic test_framing_error();
    int l;
    logic [7:0] prior;
    set_bc(9);
    clear_queues();
    prior = last_ch;
    send_frame(8'hA5, 1'b0, -1, l);
    idle(bc_cur + 1);
    checks++;
    if (obs_q.size() !== 0) begin
      failures++;
      $display("FAIL frame_err_strobe: got %0d strobes expected 0", obs_q.size());
    end
    checks++;
    if (bus.ch !== prior) begin
      failures++;
      $display("FAIL frame_err_ch: got %h expected %h", bus.ch, prior);
    end
    send_frame(8'h3C, 1'b1, -1, l);
    expect_byte(8'h3C, l);
    idle(30);
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL frame_err_next_count: got %0d strobes expected 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].d !== 8'h3C || obs_q[0].e !== exp_q[0].e) begin
        failures++;
        $display("FAIL frame_err_next_byte: got %h@%0d expected 3C@%0d", obs_q[0].d, obs_q[0].e, exp_q[0].e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int l;
    set_bc(9);
    clear_queues();
    send_frame(8'hC3, 1'b1, 5, l);
    last_ch = 8'h00;
    checks++;
    if (bus.ch !== 8'h00 || bus.ch_vld !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs: got ch=%h vld=%b expected ch=00 vld=0", bus.ch, bus.ch_vld);
    end
    idle(3 * (bc_cur + 1));
    checks++;
    if (obs_q.size() !== 0) begin
      failures++;
      $display("FAIL midrst_strobe: got %0d strobes expected 0", obs_q.size());
    end
    send_frame(8'h7E, 1'b1, -1, l);
    expect_byte(8'h7E, l);
    idle(30);
    checks++;
    if (obs_q.size() !== 1) begin
      failures++;
      $display("FAIL midrst_next_count: got %0d strobes expected 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].d !== 8'h7E || obs_q[0].e !== exp_q[0].e) begin
        failures++;
        $display("FAIL midrst_next_byte: got %h@%0d expected 7E@%0d", obs_q[0].d, obs_q[0].e, exp_q[0].e);
      end
    end
  endtask

  task automatic test_random();
    int l;
    logic [7:0] d;
    for (int batch = 0; batch < 3; batch++) begin
      set_bc(int'($urandom_range(3, 40)));
      clear_queues();
      for (int k = 0; k < 6; k++) begin
        d = 8'($urandom);
        send_frame(d, 1'b1, -1, l);
        expect_byte(d, l);
        if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2 * bc_cur)));
      end
      idle(2 * (bc_cur + 1) + 10);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_count: got %0d strobes expected %0d (bc=%0d)", batch, obs_q.size(), exp_q.size(), bc_cur);
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (obs_q[i].d !== exp_q[i].d || obs_q[i].e !== exp_q[i].e) begin
            failures++;
            $display("FAIL rand%0d_byte%0d: got %h@%0d expected %h@%0d (bc=%0d)", batch, i, obs_q[i].d, obs_q[i].e, exp_q[i].d, exp_q[i].e, bc_cur);
          end
        end
      end
    end
  endtask

  task automatic test_strobe_width();
    checks++;
    if (vld_double !== 0) begin
      failures++;
      $display("FAIL strobe_width: got %0d consecutive-high strobes expected 0", vld_double);
    end
  endtask

  initial begin
    bus.rx = 1'b1;
    bus.bc = 16'd9;
    test_reset();
    test_single(9, 8'h48, "single_bc9");
    test_back_to_back();
    test_false_start();
    test_framing_error();
    test_reset_mid_frame();
    test_single(3, 8'h48, "sweep_bc3");
    test_single(433, 8'h48, "sweep_bc433");
    test_random();
    test_strobe_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
